lpc_host_ctrl: RTL and testbench
================================

# lpc_host_ctrl

Request sequencer that sits directly upstream of the LPC host engine: accepts single-byte I/O or memory read/write requests over a valid/ready handshake, drives the host engine's control inputs (frame request, cycle strobes, address, write data, engine reset) with the cycle timing the engine requires, and returns read data or an error. Owns LPC reset sequencing after power-up and after a bus timeout.

## Interface
- RESET_CYCLES, 16: cycles ctrl_nrst_o is held low per reset sequence (≥2).
- TIMEOUT_CYCLES, 64: max cycles in WAIT before declaring a timeout (≥16).
- clk_i  in  1  clock; same clock as the host engine.
- nrst_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request accepted when req_valid_i & req_ready_o.
- req_write_i  in  1  1 = write, 0 = read.
- req_mem_i  in  1  1 = memory cycle, 0 = I/O cycle.
- req_addr_i  in  16  target address.
- req_wdata_i  in  8  write data.
- rsp_valid_o  out  1  one-cycle response pulse; no back-pressure.
- rsp_rdata_o  out  8  read data, valid with rsp_valid_o; 0 for writes/errors.
- rsp_err_o  out  1  timeout flag, valid with rsp_valid_o.
- ctrl_nrst_o, ctrl_lframe_o, ctrl_rd_status_o, ctrl_wr_status_o, ctrl_memory_cycle_o  out  1 each  to host engine.
- ctrl_addr_o  out  16; ctrl_data_o  out  8  to host engine.
- ctrl_data_i  in  8; ctrl_ready_i  in  1  from host engine.

## Operation
- All outputs registered. Reset values: req_ready_o 0, rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0, ctrl_nrst_o 0, ctrl_lframe_o 1, ctrl_rd/wr_status_o 0, ctrl_memory_cycle_o 0, ctrl_addr_o 0, ctrl_data_o 0.
- States: RESET, IDLE, FRAME, CMD, WAIT, DONE.
- RESET: ctrl_nrst_o=0 for RESET_CYCLES, then ctrl_nrst_o=1 for one further cycle (engine leaves force-reset), then IDLE.
- IDLE: req_ready_o=1. On accept: latch write/mem/addr/wdata onto ctrl_* outputs (held stable until DONE), ctrl_lframe_o=0 → FRAME.
- FRAME (1 cycle): ctrl_lframe_o=1, ctrl_rd_status_o=~write, ctrl_wr_status_o=write → CMD.
- CMD (1 cycle): strobes deasserted; timer loaded with TIMEOUT_CYCLES → WAIT.
- WAIT: ctrl_ready_i=1 → capture ctrl_data_i (reads) → DONE. Timer expiry → timeout handling.
- DONE (1 cycle): rsp_valid_o=1, rsp_err_o=0 → IDLE. Guarantees engine is back in idle before next frame.
- Timeout: rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0 in the expiry cycle (macro-dependent, see Configuration), then RESET.
- ctrl_ready_i is level, cleared by the engine on frame start; WAIT is entered after that clear, so a stale 1 from the previous transaction is never sampled.
- Async reset mid-transaction: in-flight request dropped, no response, RESET sequence runs.
- req_valid_i outside IDLE ignored; exactly one response per accepted request.

## Timing
- Accept at edge E0 → lframe low E0..E1, strobes E1..E2, WAIT from E2.
- Error-free read: engine ready ~13 cycles after frame; response ≈ 16 cycles after accept. Write similar.
- Sync wait-states extend WAIT one cycle each; total WAIT bounded by TIMEOUT_CYCLES.
- Back-to-back: earliest next accept 1 cycle after rsp_valid_o.
- First req_ready_o: RESET_CYCLES+2 cycles after nrst_i deasserts.

## Configuration
- LPC_HOST_CTRL_RETRY_EN defined: first timeout of a request emits no response, runs RESET, then reissues the latched request (FRAME); second timeout reports rsp_err_o=1. Retry flag cleared on DONE/error.
- Undefined: first timeout reports rsp_err_o=1 immediately; no retry logic present.

## Structure
- State encodings `LPC_CTRL_ST_*` added to lpc_defines.v beside the engine's states.
- Sub-module lpc_ctrl_timer: loadable down-counter with expiry flag, shared by RESET and WAIT; width $clog2(max(RESET_CYCLES,TIMEOUT_CYCLES))+1.

## Test plan
- Power-up: nrst_i released → ctrl_nrst_o low exactly 16 cycles, req_ready_o high 18 cycles after release.
- I/O read 0x0C00 against engine + LPC peripheral model returning 0xA5 → rsp_valid_o pulse, rsp_rdata_o=0xA5, rsp_err_o=0, ctrl_rd_status_o high exactly one cycle.
- Memory write 0xFED4 data 0x3C → peripheral sees addr 0xFED4/0x3C, cycle type memory-write, rsp_err_o=0, rsp_rdata_o=0.
- Peripheral drives long-wait sync forever → rsp_err_o=1 64 cycles after WAIT entry (macro off); with macro on, ctrl_nrst_o pulse, reissue, error after second timeout.
- Two back-to-back reads (0x11, 0x22) with req_valid_i held → two responses in order, no overlap, second frame after DONE.
- nrst_i asserted during WAIT → all outputs to reset values immediately, no rsp_valid_o, full reset sequence follows.

Source files
------------

// File: rtl/lpc_host_ctrl_pkg.sv
// Shared types and helpers for the LPC host request sequencer.
package lpc_host_ctrl_pkg;

  // Sequencer states, kept beside the host engine's own state names.
  typedef enum logic [2:0] {
    LPC_CTRL_ST_RESET = 3'd0,
    LPC_CTRL_ST_IDLE  = 3'd1,
    LPC_CTRL_ST_FRAME = 3'd2,
    LPC_CTRL_ST_CMD   = 3'd3,
    LPC_CTRL_ST_WAIT  = 3'd4,
    LPC_CTRL_ST_DONE  = 3'd5
  } lpc_ctrl_state_e;

  // The timer must hold whichever of the two load values is larger.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/lpc_ctrl_timer.sv
// Loadable down-counter shared by the reset sequence and the WAIT timeout.
// expired_o is high during the last counted cycle (count == 1), so an
// enabled edge seen with expired_o high is the final one of the interval.
module lpc_ctrl_timer #(
  parameter int WIDTH = 7
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_reg;

  // Load has priority; counting stops at zero.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      count_reg <= '0;
    end else if (load_i) begin
      count_reg <= load_val_i;
    end else if (en_i && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expired_o = (count_reg == WIDTH'(1));

endmodule

// File: rtl/lpc_host_ctrl.sv
// LPC host request sequencer: accepts single-byte I/O/memory requests,
// drives the host engine's control inputs with the required cycle timing,
// returns read data or a timeout error, and owns LPC reset sequencing.
// Optional feature: define LPC_HOST_CTRL_RETRY_EN to reissue a request once
// (after a full reset sequence) before reporting a timeout error.
module lpc_host_ctrl
  import lpc_host_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic        req_mem_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_wdata_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        ctrl_nrst_o,
  output logic        ctrl_lframe_o,
  output logic        ctrl_rd_status_o,
  output logic        ctrl_wr_status_o,
  output logic        ctrl_memory_cycle_o,
  output logic [15:0] ctrl_addr_o,
  output logic [7:0]  ctrl_data_o,
  input  logic [7:0]  ctrl_data_i,
  input  logic        ctrl_ready_i
);

  localparam int TIMER_W = timer_width(RESET_CYCLES, TIMEOUT_CYCLES);

  lpc_ctrl_state_e state_reg, state_next;
  logic        req_ready_reg, req_ready_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic [7:0]  rsp_rdata_reg, rsp_rdata_next;
  logic        rsp_err_reg, rsp_err_next;
  logic        nrst_out_reg, nrst_out_next;
  logic        lframe_reg, lframe_next;
  logic        rd_reg, rd_next;
  logic        wr_reg, wr_next;
  logic        mem_reg, mem_next;
  logic [15:0] addr_reg, addr_next;
  logic [7:0]  data_reg, data_next;
  logic        write_reg, write_next;
  logic [7:0]  rdata_cap_reg, rdata_cap_next;
  logic        armed_reg, armed_next;
`ifdef LPC_HOST_CTRL_RETRY_EN
  logic        retry_reg, retry_next;
`endif

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_en;
  logic               tmr_expired;

  lpc_ctrl_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk_i      (clk_i),
    .nrst_i     (nrst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .expired_o  (tmr_expired)
  );

  // State and registered-output update.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_reg     <= LPC_CTRL_ST_RESET;
      req_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 8'h00;
      rsp_err_reg   <= 1'b0;
      nrst_out_reg  <= 1'b0;
      lframe_reg    <= 1'b1;
      rd_reg        <= 1'b0;
      wr_reg        <= 1'b0;
      mem_reg       <= 1'b0;
      addr_reg      <= 16'h0000;
      data_reg      <= 8'h00;
      write_reg     <= 1'b0;
      rdata_cap_reg <= 8'h00;
      armed_reg     <= 1'b0;
`ifdef LPC_HOST_CTRL_RETRY_EN
      retry_reg     <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      req_ready_reg <= req_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
      nrst_out_reg  <= nrst_out_next;
      lframe_reg    <= lframe_next;
      rd_reg        <= rd_next;
      wr_reg        <= wr_next;
      mem_reg       <= mem_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      write_reg     <= write_next;
      rdata_cap_reg <= rdata_cap_next;
      armed_reg     <= armed_next;
`ifdef LPC_HOST_CTRL_RETRY_EN
      retry_reg     <= retry_next;
`endif
    end
  end

  // Next-state and next-output logic; response fields are single-cycle.
  always_comb begin
    state_next     = state_reg;
    req_ready_next = req_ready_reg;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = 8'h00;
    rsp_err_next   = 1'b0;
    nrst_out_next  = nrst_out_reg;
    lframe_next    = lframe_reg;
    rd_next        = rd_reg;
    wr_next        = wr_reg;
    mem_next       = mem_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    write_next     = write_reg;
    rdata_cap_next = rdata_cap_reg;
    armed_next     = armed_reg;
`ifdef LPC_HOST_CTRL_RETRY_EN
    retry_next     = retry_reg;
`endif
    tmr_load       = 1'b0;
    tmr_val        = '0;
    tmr_en         = 1'b0;

    case (state_reg)
      LPC_CTRL_ST_RESET: begin
        if (!armed_reg) begin
          // First cycle of the sequence: start the engine-reset interval.
          tmr_load      = 1'b1;
          tmr_val       = TIMER_W'(RESET_CYCLES);
          armed_next    = 1'b1;
          nrst_out_next = 1'b0;
        end else if (!nrst_out_reg) begin
          tmr_en = 1'b1;
          if (tmr_expired) begin
            nrst_out_next = 1'b1;
          end
        end else begin
          // Engine has had one cycle out of reset.
          armed_next = 1'b0;
`ifdef LPC_HOST_CTRL_RETRY_EN
          if (retry_reg) begin
            lframe_next = 1'b0;
            state_next  = LPC_CTRL_ST_FRAME;
          end else begin
            req_ready_next = 1'b1;
            state_next     = LPC_CTRL_ST_IDLE;
          end
`else
          req_ready_next = 1'b1;
          state_next     = LPC_CTRL_ST_IDLE;
`endif
        end
      end
      LPC_CTRL_ST_IDLE: begin
        if (req_valid_i && req_ready_reg) begin
          req_ready_next = 1'b0;
          write_next     = req_write_i;
          mem_next       = req_mem_i;
          addr_next      = req_addr_i;
          data_next      = req_wdata_i;
          lframe_next    = 1'b0;
          state_next     = LPC_CTRL_ST_FRAME;
        end
      end
      LPC_CTRL_ST_FRAME: begin
        lframe_next = 1'b1;
        rd_next     = ~write_reg;
        wr_next     = write_reg;
        state_next  = LPC_CTRL_ST_CMD;
      end
      LPC_CTRL_ST_CMD: begin
        rd_next    = 1'b0;
        wr_next    = 1'b0;
        tmr_load   = 1'b1;
        tmr_val    = TIMER_W'(TIMEOUT_CYCLES);
        state_next = LPC_CTRL_ST_WAIT;
      end
      LPC_CTRL_ST_WAIT: begin
        // A ready in the final timer cycle still completes the transfer.
        if (ctrl_ready_i) begin
          rdata_cap_next = write_reg ? 8'h00 : ctrl_data_i;
          state_next     = LPC_CTRL_ST_DONE;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expired) begin
            nrst_out_next = 1'b0;
            state_next    = LPC_CTRL_ST_RESET;
`ifdef LPC_HOST_CTRL_RETRY_EN
            if (!retry_reg) begin
              retry_next = 1'b1;
            end else begin
              retry_next     = 1'b0;
              rsp_valid_next = 1'b1;
              rsp_err_next   = 1'b1;
            end
`else
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
`endif
          end
        end
      end
      LPC_CTRL_ST_DONE: begin
        rsp_valid_next = 1'b1;
        rsp_rdata_next = rdata_cap_reg;
        req_ready_next = 1'b1;
`ifdef LPC_HOST_CTRL_RETRY_EN
        retry_next     = 1'b0;
`endif
        state_next     = LPC_CTRL_ST_IDLE;
      end
      default: begin
        state_next = LPC_CTRL_ST_RESET;
      end
    endcase
  end

  assign req_ready_o         = req_ready_reg;
  assign rsp_valid_o         = rsp_valid_reg;
  assign rsp_rdata_o         = rsp_rdata_reg;
  assign rsp_err_o           = rsp_err_reg;
  assign ctrl_nrst_o         = nrst_out_reg;
  assign ctrl_lframe_o       = lframe_reg;
  assign ctrl_rd_status_o    = rd_reg;
  assign ctrl_wr_status_o    = wr_reg;
  assign ctrl_memory_cycle_o = mem_reg;
  assign ctrl_addr_o         = addr_reg;
  assign ctrl_data_o         = data_reg;

endmodule

// File: tb/tb_lpc_host_ctrl.sv
// Directed bench for lpc_host_ctrl with a simple host-engine model.
// Honours LPC_HOST_CTRL_RETRY_EN for the timeout expectations.
module tb_lpc_host_ctrl;

`ifdef LPC_HOST_CTRL_RETRY_EN
  localparam int TO_LAT = 150;
`else
  localparam int TO_LAT = 66;
`endif

  logic        clk_i;
  logic        nrst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic        req_mem_i;
  logic [15:0] req_addr_i;
  logic [7:0]  req_wdata_i;
  logic        rsp_valid_o;
  logic [7:0]  rsp_rdata_o;
  logic        rsp_err_o;
  logic        ctrl_nrst_o;
  logic        ctrl_lframe_o;
  logic        ctrl_rd_status_o;
  logic        ctrl_wr_status_o;
  logic        ctrl_memory_cycle_o;
  logic [15:0] ctrl_addr_o;
  logic [7:0]  ctrl_data_o;
  logic [7:0]  ctrl_data_i;
  logic        ctrl_ready_i;

  lpc_host_ctrl dut (
    .clk_i               (clk_i),
    .nrst_i              (nrst_i),
    .req_valid_i         (req_valid_i),
    .req_ready_o         (req_ready_o),
    .req_write_i         (req_write_i),
    .req_mem_i           (req_mem_i),
    .req_addr_i          (req_addr_i),
    .req_wdata_i         (req_wdata_i),
    .rsp_valid_o         (rsp_valid_o),
    .rsp_rdata_o         (rsp_rdata_o),
    .rsp_err_o           (rsp_err_o),
    .ctrl_nrst_o         (ctrl_nrst_o),
    .ctrl_lframe_o       (ctrl_lframe_o),
    .ctrl_rd_status_o    (ctrl_rd_status_o),
    .ctrl_wr_status_o    (ctrl_wr_status_o),
    .ctrl_memory_cycle_o (ctrl_memory_cycle_o),
    .ctrl_addr_o         (ctrl_addr_o),
    .ctrl_data_o         (ctrl_data_o),
    .ctrl_data_i         (ctrl_data_i),
    .ctrl_ready_i        (ctrl_ready_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Peripheral read contents.
  function automatic logic [7:0] periph_read(input logic [15:0] a);
    case (a)
      16'h0C00: periph_read = 8'hA5;
      16'h0011: periph_read = 8'h11;
      16'h0022: periph_read = 8'h22;
      default:  periph_read = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // Engine model: clears ready on frame start, raises it eng_lat cycles
  // after the strobe; eng_lat < 0 never answers.
  int          eng_lat = 11;
  int          eng_cnt = -1;
  int          rd_cycles = 0;
  logic [15:0] seen_addr;
  logic [7:0]  seen_data;
  logic        seen_mem;
  logic        seen_wr;

  initial begin
    ctrl_ready_i = 1'b0;
    ctrl_data_i  = 8'h00;
    seen_addr = '0; seen_data = '0; seen_mem = 1'b0; seen_wr = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!nrst_i || !ctrl_lframe_o) begin
        ctrl_ready_i = 1'b0;
        eng_cnt = -1;
      end else if (ctrl_rd_status_o || ctrl_wr_status_o) begin
        eng_cnt   = eng_lat;
        seen_addr = ctrl_addr_o;
        seen_data = ctrl_data_o;
        seen_mem  = ctrl_memory_cycle_o;
        seen_wr   = ctrl_wr_status_o;
        if (ctrl_rd_status_o) rd_cycles++;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          ctrl_ready_i = 1'b1;
          ctrl_data_i  = periph_read(seen_addr);
        end
      end
    end
  end

  // Response log.
  logic [7:0] rsp_rdata_log[$];
  logic       rsp_err_log[$];
  int         rsp_cyc_log[$];

  initial begin
    forever begin
      @(negedge clk_i);
      if (rsp_valid_o) begin
        rsp_rdata_log.push_back(rsp_rdata_o);
        rsp_err_log.push_back(rsp_err_o);
        rsp_cyc_log.push_back(cyc);
        $display("txn rsp cyc=%0d rdata=0x%02h err=%0b", cyc, rsp_rdata_o, rsp_err_o);
      end
    end
  end

  int acc_cyc = 0;

  task automatic issue(input logic wr, input logic mem, input logic [15:0] a,
                       input logic [7:0] d, output bit ok);
    ok = 1'b0;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_write_i = wr; req_mem_i = mem;
    req_addr_i = a; req_wdata_i = d;
    for (int n = 0; n < 300; n++) begin
      if (req_ready_o) begin
        acc_cyc = cyc + 1;
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output bit got);
    got = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk_i);
      if (rsp_valid_o) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_txn(input string tag, input logic wr, input logic mem,
                        input logic [15:0] a, input logic [7:0] d, input int lat,
                        input logic [7:0] exp_rd, input logic exp_err, input int exp_lat);
    bit ok;
    int c0;
    eng_lat   = lat;
    rd_cycles = 0;
    c0 = rsp_rdata_log.size();
    issue(wr, mem, a, d, ok);
    check_eq($sformatf("%s_accept", tag), 32'(ok), 32'd1);
    wait_rsp(400, ok);
    check_eq($sformatf("%s_rsp", tag), 32'(ok), 32'd1);
    check_eq($sformatf("%s_rdata", tag), 32'(rsp_rdata_o), 32'(exp_rd));
    check_eq($sformatf("%s_err", tag), 32'(rsp_err_o), 32'(exp_err));
    check_eq($sformatf("%s_nrst_after", tag), 32'(ctrl_nrst_o), 32'(!exp_err));
    check_eq($sformatf("%s_latency", tag), 32'(cyc - acc_cyc), 32'(exp_lat));
    repeat (3) @(negedge clk_i);
    check_eq($sformatf("%s_rsp_count", tag), 32'(rsp_rdata_log.size()), 32'(c0 + 1));
    $display("txn %s wr=%0b mem=%0b addr=0x%04h lat=%0d done", tag, wr, mem, a, lat);
  endtask

  // Reset released just after a negedge: engine reset low through edge 16,
  // high after edge 17, request ready after edge 18.
  task automatic check_reset_seq(input string tag);
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk_i);
      #1;
      if (k == 1)  check_eq($sformatf("%s_lframe_k1", tag), 32'(ctrl_lframe_o), 32'd1);
      if (k == 16) check_eq($sformatf("%s_nrst_k16", tag), 32'(ctrl_nrst_o), 32'd0);
      if (k == 17) begin
        check_eq($sformatf("%s_nrst_k17", tag), 32'(ctrl_nrst_o), 32'd1);
        check_eq($sformatf("%s_ready_k17", tag), 32'(req_ready_o), 32'd0);
      end
      if (k == 18) check_eq($sformatf("%s_ready_k18", tag), 32'(req_ready_o), 32'd1);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq($sformatf("%s_ready", tag), 32'(req_ready_o), 32'd0);
    check_eq($sformatf("%s_rsp_valid", tag), 32'(rsp_valid_o), 32'd0);
    check_eq($sformatf("%s_nrst", tag), 32'(ctrl_nrst_o), 32'd0);
    check_eq($sformatf("%s_lframe", tag), 32'(ctrl_lframe_o), 32'd1);
    check_eq($sformatf("%s_strobes", tag), 32'({ctrl_rd_status_o, ctrl_wr_status_o, ctrl_memory_cycle_o}), 32'd0);
    check_eq($sformatf("%s_addr", tag), 32'(ctrl_addr_o), 32'd0);
    check_eq($sformatf("%s_data", tag), 32'(ctrl_data_o), 32'd0);
  endtask

  initial begin
    bit ok;
    int c0;
    int acc1;
    int acc2;
    nrst_i = 1'b0; req_valid_i = 1'b0; req_write_i = 1'b0; req_mem_i = 1'b0;
    req_addr_i = '0; req_wdata_i = '0;

    // Power-up reset.
    repeat (3) @(negedge clk_i);
    check_reset_values("por");
    nrst_i = 1'b1;
    check_reset_seq("por_seq");

    // I/O read returning 0xA5.
    do_txn("io_rd", 1'b0, 1'b0, 16'h0C00, 8'h00, 11, 8'hA5, 1'b0, 14);
    check_eq("io_rd_strobe_cycles", 32'(rd_cycles), 32'd1);
    check_eq("io_rd_seen_mem", 32'(seen_mem), 32'd0);
    check_eq("io_rd_seen_wr", 32'(seen_wr), 32'd0);

    // Memory write.
    do_txn("mem_wr", 1'b1, 1'b1, 16'hFED4, 8'h3C, 11, 8'h00, 1'b0, 14);
    check_eq("mem_wr_seen_addr", 32'(seen_addr), 32'hFED4);
    check_eq("mem_wr_seen_data", 32'(seen_data), 32'h3C);
    check_eq("mem_wr_seen_mem", 32'(seen_mem), 32'd1);
    check_eq("mem_wr_seen_wr", 32'(seen_wr), 32'd1);
    check_eq("mem_wr_rd_strobe", 32'(rd_cycles), 32'd0);

    // Wait states, and the last-sample boundary of the timeout window.
    do_txn("ws40", 1'b0, 1'b1, 16'h1234, 8'h00, 40, 8'h12 ^ 8'h5A ^ 8'h34 ^ 8'h12, 1'b0, 43);
    do_txn("ws64", 1'b0, 1'b0, 16'h0C00, 8'h00, 64, 8'hA5, 1'b0, 67);

    // One cycle too late, and an engine that never answers.
    do_txn("ws65", 1'b0, 1'b0, 16'h0C00, 8'h00, 65, 8'h00, 1'b1, TO_LAT);
    do_txn("hang", 1'b1, 1'b0, 16'h0080, 8'h77, -1, 8'h00, 1'b1, TO_LAT);

    // Back-to-back reads with valid held.
    eng_lat = 11;
    c0 = rsp_rdata_log.size();
    acc1 = -1; acc2 = -1;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_write_i = 1'b0; req_mem_i = 1'b0; req_addr_i = 16'h0011;
    for (int n = 0; n < 300; n++) begin
      if (req_ready_o) begin acc1 = cyc + 1; break; end
      @(negedge clk_i);
    end
    @(negedge clk_i);
    req_addr_i = 16'h0022;
    for (int n = 0; n < 300; n++) begin
      if (req_ready_o) begin acc2 = cyc + 1; break; end
      @(negedge clk_i);
    end
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    wait_rsp(200, ok);
    repeat (3) @(negedge clk_i);
    check_eq("b2b_accept1", 32'(acc1 >= 0), 32'd1);
    check_eq("b2b_rsp_count", 32'(rsp_rdata_log.size()), 32'(c0 + 2));
    check_eq("b2b_rdata1", 32'(rsp_rdata_log[c0]), 32'h11);
    check_eq("b2b_rdata2", 32'(rsp_rdata_log[c0 + 1]), 32'h22);
    check_eq("b2b_next_accept", 32'(acc2 - rsp_cyc_log[c0]), 32'd1);
    check_eq("b2b_rsp_gap", 32'(rsp_cyc_log[c0 + 1] - rsp_cyc_log[c0]), 32'd15);
    $display("txn b2b acc1=%0d acc2=%0d done", acc1, acc2);

    // Asynchronous reset while waiting on the engine.
    eng_lat = -1;
    c0 = rsp_rdata_log.size();
    issue(1'b0, 1'b1, 16'h0C00, 8'h00, ok);
    check_eq("arst_accept", 32'(ok), 32'd1);
    repeat (10) @(negedge clk_i);
    #2 nrst_i = 1'b0;
    #1 check_reset_values("arst");
    repeat (3) @(negedge clk_i);
    nrst_i = 1'b1;
    check_reset_seq("arst_seq");
    repeat (5) @(negedge clk_i);
    check_eq("arst_no_rsp", 32'(rsp_rdata_log.size()), 32'(c0));
    $display("txn arst done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
